// File: rtl/input_buffer_logic_pkg.sv
// input_buffer_logic_pkg: shared packet type and receive FSM states
package input_buffer_logic_pkg;
  typedef logic [3:0][7:0] pkt_t;
  typedef enum logic [1:0] {IDLE, COLLECT, PUSH} ib_state_t;
endpackage

// File: rtl/input_buffer_logic_if.sv
// input_buffer_logic_if: inbound byte link and packet consumer signals
interface input_buffer_logic_if;
  import input_buffer_logic_pkg::*;
  logic [7:0] payload_inbound;
  logic put_inbound;
  logic ready_inbound;
  pkt_t pkt;
  logic pkt_avail;
  logic read_pkt;
  logic frame_err;
  logic overrun;
  modport slave (
    input payload_inbound, put_inbound, read_pkt,
    output ready_inbound, pkt, pkt_avail, frame_err, overrun
  );
  modport master (
    output payload_inbound, put_inbound, read_pkt,
    input ready_inbound, pkt, pkt_avail, frame_err, overrun
  );
endinterface

// File: rtl/input_buffer_logic_pkt_fifo.sv
// pkt_fifo: packet queue with combinational head read and push-while-full-with-pop
module pkt_fifo
  import input_buffer_logic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  pkt_t data_in,
  input  logic we,
  input  logic re,
  output pkt_t data_out,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  pkt_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic do_w, do_r;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_r = re && !empty;
  assign do_w = we && (!full || do_r);
  assign data_out = mem[rptr];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_w) begin
        mem[wptr] <= data_in;
        wptr <= wptr + 1'b1;
      end
      if (do_r) rptr <= rptr + 1'b1;
      count <= count + CW'(do_w) - CW'(do_r);
    end
  end
endmodule

// File: rtl/input_buffer_logic.sv
// input_buffer_logic: assembles MSB-first bytes into 32-bit packets and queues them
module input_buffer_logic
  import input_buffer_logic_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 8
) (
  input logic clock,
  input logic reset,
  input_buffer_logic_if.slave bus
);
  localparam int IW = $clog2(TIMEOUT + 1);
  ib_state_t state;
  logic [1:0] cnt;
  logic [IW-1:0] idle_cnt;
  pkt_t asm_q;
  logic accept, space, full, empty;
  assign bus.ready_inbound = state != PUSH;
  assign accept = bus.put_inbound && bus.ready_inbound;
  assign space = !full || bus.read_pkt;
  assign bus.pkt_avail = !empty;
  pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .data_in(asm_q),
    .we(state == PUSH && space),
    .re(bus.read_pkt),
    .data_out(bus.pkt),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idle_cnt <= '0;
      asm_q <= '0;
      bus.frame_err <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.frame_err <= 1'b0;
      bus.overrun <= bus.put_inbound && !bus.ready_inbound;
      if (accept) asm_q <= {asm_q[2:0], bus.payload_inbound};
      case (state)
        IDLE: if (accept) begin
          cnt <= 2'd1;
          idle_cnt <= '0;
          state <= COLLECT;
        end
        COLLECT: if (accept) begin
          cnt <= cnt + 2'd1;
          idle_cnt <= '0;
          if (cnt == 2'd3) state <= PUSH;
        end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
          // idle budget exhausted: drop the partial packet
          state <= IDLE;
          cnt <= '0;
          idle_cnt <= '0;
          bus.frame_err <= 1'b1;
        end else idle_cnt <= idle_cnt + 1'b1;
        PUSH: if (space) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_buffer_logic.sv
// tb_input_buffer_logic: vector table, corner sequences and random traffic vs queue model
module tb_input_buffer_logic;
  localparam int D = 4;
  localparam int TO = 8;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  input_buffer_logic_if bus();
  input_buffer_logic #(.FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  logic [7:0] bq [$];
  logic [31:0] fq [$];
  logic pend;
  logic [31:0] pend_pkt;
  int gap;
  typedef struct {
    logic put;
    logic [7:0] b;
    logic rd;
    logic e_ready;
    logic e_avail;
    logic [31:0] e_pkt;
  } vec_t;
  vec_t tbl [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    bq.delete();
    fq.delete();
    pend = 0;
    pend_pkt = 0;
    gap = 0;
  endtask
  task automatic step(input logic p, input logic [7:0] b, input logic r);
    logic ef, eo, op, sp;
    bus.put_inbound = p;
    bus.payload_inbound = b;
    bus.read_pkt = r;
    op = pend;
    eo = p && op;
    ef = 0;
    sp = fq.size() < D || r;
    if (r && fq.size() > 0) void'(fq.pop_front());
    if (op && sp) begin
      fq.push_back(pend_pkt);
      pend = 0;
    end
    if (p && !op) begin
      bq.push_back(b);
      gap = 0;
      if (bq.size() == 4) begin
        pend = 1;
        pend_pkt = {bq[0], bq[1], bq[2], bq[3]};
        bq.delete();
      end
    end else if (bq.size() > 0) begin
      gap++;
      if (gap == TO) begin
        bq.delete();
        gap = 0;
        ef = 1;
      end
    end
    @(posedge clock);
    #1;
    if (bus.frame_err) ferr_seen++;
    chk("ready", 32'(bus.ready_inbound), 32'(!pend));
    chk("avail", 32'(bus.pkt_avail), 32'(fq.size() > 0));
    chk("frame_err", 32'(bus.frame_err), 32'(ef));
    chk("overrun", 32'(bus.overrun), 32'(eo));
    if (fq.size() > 0) chk("pkt", bus.pkt, fq[0]);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask
  task automatic send(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) step(1, t[31-8*i -: 8], 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready_inbound), 32'd1);
    chk({tag, "_avail"}, 32'(bus.pkt_avail), 32'd0);
    chk({tag, "_pkt"}, bus.pkt, 32'd0);
    chk({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
    chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
  endtask
  initial begin
    int f0;
    bus.put_inbound = 0;
    bus.payload_inbound = 0;
    bus.read_pkt = 0;
    model_reset();
    tbl[0] = '{1, 8'hDE, 0, 1, 0, 32'h0};
    tbl[1] = '{1, 8'hAD, 0, 1, 0, 32'h0};
    tbl[2] = '{1, 8'hBE, 0, 1, 0, 32'h0};
    tbl[3] = '{1, 8'hEF, 0, 0, 0, 32'h0};
    tbl[4] = '{0, 8'h00, 0, 1, 1, 32'hDEADBEEF};
    tbl[5] = '{0, 8'h00, 1, 1, 0, 32'h0};
    tbl[6] = '{0, 8'h00, 0, 1, 0, 32'h0};
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("rst");
    reset = 0;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].put, tbl[i].b, tbl[i].rd);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.ready_inbound), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_avail", i), 32'(bus.pkt_avail), 32'(tbl[i].e_avail));
      if (tbl[i].e_avail) chk($sformatf("tbl%0d_pkt", i), bus.pkt, tbl[i].e_pkt);
    end
    f0 = ferr_seen;
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    idle(TO);
    chk("timeout_pulses", 32'(ferr_seen - f0), 32'd1);
    send(32'h33445566);
    idle(1);
    chk("timeout_pkt", bus.pkt, 32'h33445566);
    step(0, 8'h00, 1);
    chk("timeout_single", 32'(bus.pkt_avail), 32'd0);
    for (int k = 0; k < D; k++) begin
      send(32'hA0B0C0D0 + 32'(k));
      idle(1);
    end
    send(32'hCAFEF00D);
    for (int i = 0; i < 3; i++) step(1, 8'h5A + 8'(i), 0);
    chk("full_hold_ready", 32'(bus.ready_inbound), 32'd0);
    chk("full_hold_ovr", 32'(bus.overrun), 32'd1);
    step(0, 8'h00, 1);
    chk("full_pop_head", bus.pkt, 32'hA0B0C0D1);
    for (int k = 0; k < D; k++) step(0, 8'h00, 1);
    chk("full_drained", 32'(bus.pkt_avail), 32'd0);
    f0 = ferr_seen;
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h10 * 8'(i + 1), 0);
      if (i < 3) idle(TO - 1);
    end
    idle(1);
    chk("gap_no_ferr", 32'(ferr_seen - f0), 32'd0);
    chk("gap_pkt", bus.pkt, 32'h10203040);
    step(0, 8'h00, 1);
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 0);
    reset = 1;
    #2;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
    send(32'h9ABCDEF0);
    idle(1);
    chk("post_rst_pkt", bus.pkt, 32'h9ABCDEF0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("empty_read_avail", 32'(bus.pkt_avail), 32'd0);
    send(32'h0F1E2D3C);
    idle(1);
    chk("empty_read_pkt", bus.pkt, 32'h0F1E2D3C);
    for (int i = 0; i < 1500; i++) begin
      logic p;
      p = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      step(p, 8'($urandom), $urandom_range(0, 2) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
